// File: rtl/sram_init_pkg.sv
// Shared types and constants for the SRAM initiator: FSM states, SRAM
// command encodings, default widths and the saturating counter helper.
package sram_init_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;
    localparam int STATS_W    = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/sram_init_addr_gen.sv
// Loadable wrapping address counter with a beat down-counter; last flags
// that the beat currently addressed is the final one of the burst.
module sram_init_addr_gen
    import sram_init_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              last
);

    logic [LEN_W-1:0] beats_left;

    // Address wraps naturally at 2^ADDR_W; beats_left holds remaining beats minus one.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cur_addr   <= '0;
            beats_left <= '0;
        end else if (load) begin
            cur_addr   <= load_addr;
            beats_left <= load_len;
        end else if (step) begin
            cur_addr   <= cur_addr + ADDR_W'(1);
            beats_left <= beats_left - LEN_W'(1);
        end
    end

    assign last = (beats_left == '0);

endmodule

// File: rtl/sram_initiator.sv
// Valid/ready burst initiator for a 1-cycle-latency synchronous SRAM.
// Optional burst statistics outputs are enabled with SRAM_INIT_STATS_EN.
module sram_initiator
    import sram_init_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_RW,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [LEN_W-1:0]  Req_Len,
    input  logic              Wr_Valid,
    output logic              Wr_Ready,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic              Rd_Valid,
    output logic [DATA_W-1:0] Rd_Data,
    output logic              Done,
    output logic              Mem_En,
    output logic              Mem_RW,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData
`ifdef SRAM_INIT_STATS_EN
    ,
    output logic [STATS_W-1:0] Wr_Count,
    output logic [STATS_W-1:0] Rd_Count
`endif
);

    state_t            state, state_nx;
    logic              rd_pend, rd_pend_nx;
    logic              rw_q;
    logic              load, step, last;
    logic [ADDR_W-1:0] cur_addr;

    logic              req_ready_c, wr_ready_c, done_c, mem_en_c, mem_rw_c;
    logic [DATA_W-1:0] mem_wdata_c;

    sram_init_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (load),
        .load_addr (Req_Addr),
        .load_len  (Req_Len),
        .step      (step),
        .cur_addr  (cur_addr),
        .last      (last)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            rd_pend <= 1'b0;
            rw_q    <= MEM_READ;
        end else begin
            state   <= state_nx;
            rd_pend <= rd_pend_nx;
            if (load) begin
                rw_q <= Req_RW;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        req_ready_c = 1'b0;
        wr_ready_c  = 1'b0;
        done_c      = 1'b0;
        mem_en_c    = 1'b0;
        mem_rw_c    = MEM_READ;
        mem_wdata_c = '0;
        load        = 1'b0;
        step        = 1'b0;
        rd_pend_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (Req_Valid) begin
                    load     = 1'b1;
                    state_nx = (Req_RW == MEM_WRITE) ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready_c = 1'b1;
                if (Wr_Valid) begin
                    mem_en_c    = 1'b1;
                    mem_rw_c    = MEM_WRITE;
                    mem_wdata_c = Wr_Data;
                    step        = 1'b1;
                    if (last) begin
                        state_nx = DONE;
                    end
                end
            end
            READ: begin
                mem_en_c   = 1'b1;
                step       = 1'b1;
                rd_pend_nx = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset forces every output quiet even before the state register settles.
    assign Req_Ready = req_ready_c & ~Rst;
    assign Wr_Ready  = wr_ready_c & ~Rst;
    assign Done      = done_c & ~Rst;
    assign Mem_En    = mem_en_c & ~Rst;
    assign Mem_RW    = mem_rw_c & ~Rst;
    assign Mem_Addr  = Rst ? '0 : cur_addr;
    assign Mem_WData = Rst ? '0 : mem_wdata_c;
    assign Rd_Valid  = rd_pend & ~Rst;
    assign Rd_Data   = Mem_RData;

`ifdef SRAM_INIT_STATS_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Wr_Count <= '0;
            Rd_Count <= '0;
        end else if (state == DONE) begin
            if (rw_q == MEM_WRITE) begin
                Wr_Count <= sat_inc(Wr_Count);
            end else begin
                Rd_Count <= sat_inc(Rd_Count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_initiator.sv
// Directed bench for sram_initiator with a behavioural 16x32 synchronous SRAM.
module tb_sram_initiator;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Req_Valid, Req_Ready, Req_RW;
    logic [3:0]  Req_Addr;
    logic [3:0]  Req_Len;
    logic        Wr_Valid, Wr_Ready;
    logic [31:0] Wr_Data;
    logic        Rd_Valid;
    logic [31:0] Rd_Data;
    logic        Done;
    logic        Mem_En, Mem_RW;
    logic [3:0]  Mem_Addr;
    logic [31:0] Mem_WData, Mem_RData;
`ifdef SRAM_INIT_STATS_EN
    logic [15:0] Wr_Count, Rd_Count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [16];
    logic        preload = 1'b0;

    logic [3:0]  wrap_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic [31:0] wrap_data [4] = '{32'h10E, 32'h10F, 32'h100, 32'h101};

    always #5 Clk = ~Clk;

    sram_initiator dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req_Valid (Req_Valid),
        .Req_Ready (Req_Ready),
        .Req_RW    (Req_RW),
        .Req_Addr  (Req_Addr),
        .Req_Len   (Req_Len),
        .Wr_Valid  (Wr_Valid),
        .Wr_Ready  (Wr_Ready),
        .Wr_Data   (Wr_Data),
        .Rd_Valid  (Rd_Valid),
        .Rd_Data   (Rd_Data),
        .Done      (Done),
        .Mem_En    (Mem_En),
        .Mem_RW    (Mem_RW),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData),
        .Mem_RData (Mem_RData)
`ifdef SRAM_INIT_STATS_EN
        ,
        .Wr_Count  (Wr_Count),
        .Rd_Count  (Rd_Count)
`endif
    );

    // Synchronous SRAM: registered read data, one-cycle latency.
    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + 32'(i);
        end else if (Mem_En) begin
            if (Mem_RW) mem[Mem_Addr] <= Mem_WData;
            else        Mem_RData <= mem[Mem_Addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Rst = 1'b1; Req_Valid = 0; Req_RW = 0; Req_Addr = 0; Req_Len = 0;
        Wr_Valid = 0; Wr_Data = 0;

        // Reset
        tick(); tick(); #1;
        chk("rst_req_ready", 32'(Req_Ready), 0);
        chk("rst_wr_ready",  32'(Wr_Ready), 0);
        chk("rst_rd_valid",  32'(Rd_Valid), 0);
        chk("rst_done",      32'(Done), 0);
        chk("rst_mem_en",    32'(Mem_En), 0);
        chk("rst_mem_rw",    32'(Mem_RW), 0);
        chk("rst_mem_addr",  32'(Mem_Addr), 0);
        chk("rst_mem_wdata", Mem_WData, 0);
        tick();
        Rst = 1'b0; #1;
        chk("post_rst_req_ready", 32'(Req_Ready), 1);
        chk("post_rst_mem_en",    32'(Mem_En), 0);

        // Single write of 0xDEADBEEF to address 3
        Req_Valid = 1; Req_RW = 1; Req_Addr = 3; Req_Len = 0;
        Wr_Valid = 1; Wr_Data = 32'hDEADBEEF;
        tick(); Req_Valid = 0; #1;
        chk("sw_mem_en",    32'(Mem_En), 1);
        chk("sw_mem_rw",    32'(Mem_RW), 1);
        chk("sw_mem_addr",  32'(Mem_Addr), 3);
        chk("sw_mem_wdata", Mem_WData, 32'hDEADBEEF);
        chk("sw_wr_ready",  32'(Wr_Ready), 1);
        tick(); Wr_Valid = 0; #1;
        chk("sw_done",      32'(Done), 1);
        chk("sw_done_en",   32'(Mem_En), 0);
        chk("sw_done_wd",   Mem_WData, 0);
        chk("sw_done_rdy",  32'(Req_Ready), 0);
        chk("sw_mem3",      mem[3], 32'hDEADBEEF);

        // Single read back from address 3
        tick();
        chk("sr_req_ready", 32'(Req_Ready), 1);
        Req_Valid = 1; Req_RW = 0; Req_Addr = 3; Req_Len = 0;
        tick(); Req_Valid = 0; #1;
        chk("sr_mem_en",   32'(Mem_En), 1);
        chk("sr_mem_rw",   32'(Mem_RW), 0);
        chk("sr_mem_addr", 32'(Mem_Addr), 3);
        chk("sr_rd_valid0", 32'(Rd_Valid), 0);
        tick(); #1;
        chk("sr_rd_valid", 32'(Rd_Valid), 1);
        chk("sr_rd_data",  Rd_Data, 32'hDEADBEEF);
        chk("sr_done",     32'(Done), 1);
        tick(); #1;
        chk("sr_idle_rv",  32'(Rd_Valid), 0);
        chk("sr_idle_rdy", 32'(Req_Ready), 1);

        // Wrapping read burst over preloaded memory
        preload = 1; tick(); preload = 0;
        Req_Valid = 1; Req_RW = 0; Req_Addr = 14; Req_Len = 3;
        for (int k = 0; k < 4; k++) begin
            tick(); Req_Valid = 0; #1;
            chk("wr_mem_en",   32'(Mem_En), 1);
            chk("wr_mem_addr", 32'(Mem_Addr), 32'(wrap_addr[k]));
            chk("wr_rd_valid", 32'(Rd_Valid), (k > 0) ? 1 : 0);
            chk("wr_done_early", 32'(Done), 0);
            if (k > 0) chk("wr_rd_data", Rd_Data, wrap_data[k-1]);
        end
        tick(); #1;
        chk("wr_last_valid", 32'(Rd_Valid), 1);
        chk("wr_last_data",  Rd_Data, wrap_data[3]);
        chk("wr_done",       32'(Done), 1);
        chk("wr_done_en",    32'(Mem_En), 0);
        tick(); #1;
        chk("wr_idle_rv",  32'(Rd_Valid), 0);
        chk("wr_idle_rdy", 32'(Req_Ready), 1);

        // Write burst of 3 with a one-cycle Wr_Valid gap
        Req_Valid = 1; Req_RW = 1; Req_Addr = 5; Req_Len = 2;
        Wr_Valid = 1; Wr_Data = 32'hA0;
        tick(); Req_Valid = 0; #1;
        chk("st_b0_en",   32'(Mem_En), 1);
        chk("st_b0_addr", 32'(Mem_Addr), 5);
        chk("st_b0_data", Mem_WData, 32'hA0);
        tick(); Wr_Valid = 0; #1;
        chk("st_gap_en",    32'(Mem_En), 0);
        chk("st_gap_addr",  32'(Mem_Addr), 6);
        chk("st_gap_rw",    32'(Mem_RW), 0);
        chk("st_gap_wd",    Mem_WData, 0);
        chk("st_gap_wrdy",  32'(Wr_Ready), 1);
        tick(); #1;
        chk("st_gap2_addr", 32'(Mem_Addr), 6);
        Wr_Valid = 1; Wr_Data = 32'hA1; #1;
        chk("st_b1_en",   32'(Mem_En), 1);
        chk("st_b1_addr", 32'(Mem_Addr), 6);
        tick(); Wr_Data = 32'hA2; #1;
        chk("st_b2_addr", 32'(Mem_Addr), 7);
        chk("st_b2_done", 32'(Done), 0);
        tick(); Wr_Valid = 0; #1;
        chk("st_done", 32'(Done), 1);
        chk("st_mem5", mem[5], 32'hA0);
        chk("st_mem6", mem[6], 32'hA1);
        chk("st_mem7", mem[7], 32'hA2);
        tick();
`ifdef SRAM_INIT_STATS_EN
        chk("stats_wr", 32'(Wr_Count), 2);
        chk("stats_rd", 32'(Rd_Count), 2);
`endif

        // Reset during the second READ cycle of a 6-beat burst
        Req_Valid = 1; Req_RW = 0; Req_Addr = 0; Req_Len = 5;
        tick(); Req_Valid = 0; #1;
        chk("mr_first_en", 32'(Mem_En), 1);
        tick(); Rst = 1; #1;
        chk("mr_rst_rv", 32'(Rd_Valid), 0);
        chk("mr_rst_en", 32'(Mem_En), 0);
        tick(); Rst = 0; #1;
        chk("mr_rv",   32'(Rd_Valid), 0);
        chk("mr_done", 32'(Done), 0);
        chk("mr_rdy",  32'(Req_Ready), 1);
        chk("mr_en",   32'(Mem_En), 0);
`ifdef SRAM_INIT_STATS_EN
        chk("stats_wr_rst", 32'(Wr_Count), 0);
        chk("stats_rd_rst", 32'(Rd_Count), 0);
`endif
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("mr_quiet_done", 32'(Done), 0);
            chk("mr_quiet_rv",   32'(Rd_Valid), 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
